dfd_cla_node_sequencer: RTL and testbench

// Sequencer for the CLA event/action fabric. Holds the current CLA node and evaluates that

---
 rtl/dfd_cla_node_sequencer.sv | 111 +++++++++++
 tb/tb_dfd_cla_node_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dfd_cla_node_sequencer.sv
// CLA node sequencer: evaluates the current node's event-action pairs against the event bus,
// pulses the matching actions one cycle later and steps to the next node.
module dfd_cla_node_sequencer #(
   parameter int NUM_NODES     = 4,
   parameter int EAPS_PER_NODE = 4,
   parameter int NUM_EVENTS    = 64,
   parameter int NUM_ACTIONS   = 64
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   cla_en_i,
   input  logic [NUM_NODES*EAPS_PER_NODE*16-1:0]  eap_cfg_i,
   input  logic [NUM_EVENTS-1:0]                  event_bus_i,
   output logic [NUM_ACTIONS-1:0]                 action_bus_o,
   output logic [$clog2(NUM_NODES)-1:0]           cur_node_o,
   output logic                                   node_chg_o,
   output logic                                   halted_o
);

   localparam int NID_W = $clog2(NUM_NODES);
   localparam int EV_W  = $clog2(NUM_EVENTS);
   localparam int AC_W  = $clog2(NUM_ACTIONS);

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_ARMED  = 2'b01;
   localparam logic [1:0] ST_HALTED = 2'b10;

   localparam logic [NUM_ACTIONS-1:0] ONE_ACT = {{(NUM_ACTIONS-1){1'b0}}, 1'b1};

   logic [1:0]             r_state;
   logic [NID_W-1:0]       r_node;
   logic [NUM_ACTIONS-1:0] r_action;
   logic                   r_chg;
   logic                   r_halted;

   logic [NUM_ACTIONS-1:0] w_actions;
   logic [NID_W-1:0]       w_next;
   logic [15:0]            w_entry;
   logic                   w_hit;
   logic                   w_nn_ok;

   // Scan from the highest EAP down so the lowest-index hit decides the next node.
   always_comb begin
      w_actions = '0;
      w_next    = r_node;
      w_entry   = 16'd0;
      w_hit     = 1'b0;
      w_nn_ok   = 1'b0;
      for (int e = EAPS_PER_NODE - 1; e >= 0; e--) begin
         w_entry   = eap_cfg_i[(int'(r_node) * EAPS_PER_NODE + e) * 16 +: 16];
         w_hit     = w_entry[15] & (event_bus_i[w_entry[9 +: EV_W]] ^ w_entry[0]);
         w_nn_ok   = ({30'd0, w_entry[2:1]} < NUM_NODES);
         w_actions = w_actions | (w_hit ? (ONE_ACT << w_entry[3 +: AC_W]) : '0);
         // An out-of-range target from the winning EAP holds the node rather than deferring.
         w_next    = w_hit ? (w_nn_ok ? w_entry[1 +: NID_W] : r_node) : w_next;
      end
      w_actions[0] = 1'b0;
   end

   // Sequencer state, node and registered action/status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_node   <= '0;
         r_action <= '0;
         r_chg    <= 1'b0;
         r_halted <= 1'b0;
      end else if (!cla_en_i) begin
         r_state  <= ST_IDLE;
         r_node   <= '0;
         r_action <= '0;
         r_chg    <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state  <= ST_ARMED;
               r_node   <= '0;
               r_action <= '0;
               r_chg    <= 1'b0;
               r_halted <= 1'b0;
            end
            ST_ARMED, ST_HALTED: begin
               r_node   <= w_next;
               r_action <= w_actions;
               r_chg    <= (w_next != r_node);
               if (w_actions[1]) begin
                  r_state  <= ST_HALTED;
                  r_halted <= 1'b1;
               end else begin
                  r_state  <= r_state;
                  r_halted <= r_halted;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_node   <= '0;
               r_action <= '0;
               r_chg    <= 1'b0;
               r_halted <= 1'b0;
            end
         endcase
      end
   end

   assign action_bus_o = r_action;
   assign cur_node_o   = r_node;
   assign node_chg_o   = r_chg;
   assign halted_o     = r_halted;

endmodule

// File: tb/tb_dfd_cla_node_sequencer.sv
// Directed + randomised bench for dfd_cla_node_sequencer with a cycle-level reference model.
module tb_dfd_cla_node_sequencer;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         cla_en = 1'b0;
   logic [255:0] cfg = '0;
   logic [63:0]  ev = '0;
   logic [63:0]  act;
   logic [1:0]   node;
   logic         chg;
   logic         halted;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;

   // model: outputs the DUT must present after the next rising edge
   bit          m_armed = 1'b0;
   int          m_node  = 0;
   bit          m_halt  = 1'b0;
   logic [63:0] e_act   = '0;
   bit          e_chg   = 1'b0;

   dfd_cla_node_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .cla_en_i     (cla_en),
      .eap_cfg_i    (cfg),
      .event_bus_i  (ev),
      .action_bus_o (act),
      .cur_node_o   (node),
      .node_chg_o   (chg),
      .halted_o     (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mk(input logic v, input int evs, input int acs, input int nn, input logic inv);
      logic [5:0] e6;
      logic [5:0] a6;
      logic [1:0] n2;
      e6 = evs[5:0];
      a6 = acs[5:0];
      n2 = nn[1:0];
      return {v, e6, a6, n2, inv};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic put(input int n, input int e, input logic [15:0] v);
      cfg[(n*4+e)*16 +: 16] = v;
   endtask

   // Reference model: compare what was predicted, then predict the next edge from live inputs.
   always @(negedge clk) begin
      logic [63:0] acts;
      logic [15:0] ent;
      int          first;
      int          nn;
      if (reset) begin
         m_armed = 1'b0; m_node = 0; m_halt = 1'b0; e_act = '0; e_chg = 1'b0;
      end
      if (chk_on) begin
         chk("action_bus", act, e_act);
         chk("cur_node", {62'd0, node}, m_node);
         chk("node_chg", {63'd0, chg}, {63'd0, e_chg});
         chk("halted", {63'd0, halted}, {63'd0, m_halt});
      end
      if (reset || !cla_en) begin
         m_armed = 1'b0; m_node = 0; m_halt = 1'b0; e_act = '0; e_chg = 1'b0;
      end else if (!m_armed) begin
         m_armed = 1'b1; e_act = '0; e_chg = 1'b0;
      end else begin
         acts  = '0;
         first = -1;
         for (int e = 0; e < 4; e++) begin
            ent = cfg[(m_node*4+e)*16 +: 16];
            if (ent[15] && (ev[ent[14:9]] != ent[0])) begin
               acts[ent[8:3]] = 1'b1;
               if (first < 0) first = e;
            end
         end
         acts[0] = 1'b0;
         e_chg = 1'b0;
         if (first >= 0) begin
            ent = cfg[(m_node*4+first)*16 +: 16];
            nn  = int'(ent[2:1]);
            e_chg  = (nn != m_node);
            m_node = nn;
         end
         e_act = acts;
         if (acts[1]) m_halt = 1'b1;
      end
   end

   initial begin
      repeat (3) cyc();
      chk_on = 1'b1;
      chk("reset_act", act, 64'd0);
      chk("reset_node", {62'd0, node}, 64'd0);
      reset = 1'b0;
      cyc();

      // single EAP transition node0 -> node1
      put(0, 0, mk(1'b1, 5, 4, 1, 1'b0));
      cla_en = 1'b1; cyc();
      ev[5] = 1'b1; cyc();
      chk("t1_act", act, 64'h10);
      chk("t1_node", {62'd0, node}, 64'd1);
      chk("t1_chg", {63'd0, chg}, 64'd1);
      ev = '0; cyc();
      chk("t1_chg_once", {63'd0, chg}, 64'd0);
      ev[5] = 1'b1; cyc();
      chk("t1_node1_no_act", act, 64'd0);
      chk("t1_node_held", {62'd0, node}, 64'd1);

      // two hits: actions OR'd, lowest EAP picks the node
      cla_en = 1'b0; ev = '0; cfg = '0; cyc();
      put(0, 1, mk(1'b1, 6, 7, 2, 1'b0));
      put(0, 3, mk(1'b1, 6, 8, 3, 1'b0));
      cla_en = 1'b1; cyc();
      ev[6] = 1'b1; cyc();
      chk("t2_act", act, 64'h180);
      chk("t2_node", {62'd0, node}, 64'd2);

      // inverted event fires the clock-halt action
      cla_en = 1'b0; ev = '0; cfg = '0; cyc();
      put(0, 0, mk(1'b1, 9, 1, 0, 1'b1));
      cla_en = 1'b1; cyc();
      cyc();
      chk("t3_act", act, 64'h2);
      chk("t3_halted", {63'd0, halted}, 64'd1);
      chk("t3_node", {62'd0, node}, 64'd0);
      chk("t3_chg", {63'd0, chg}, 64'd0);
      cla_en = 1'b0; cyc();
      chk("t3_unhalt", {63'd0, halted}, 64'd0);

      // action_sel 0 is suppressed but the transition is taken
      cfg = '0;
      put(0, 2, mk(1'b1, 10, 0, 3, 1'b0));
      put(3, 0, mk(1'b0, 11, 5, 1, 1'b0));
      cla_en = 1'b1; cyc();
      ev[10] = 1'b1; cyc();
      chk("t4_act", act, 64'd0);
      chk("t4_node", {62'd0, node}, 64'd3);
      ev[11] = 1'b1; cyc();
      chk("t5_invalid_act", act, 64'd0);
      chk("t5_invalid_node", {62'd0, node}, 64'd3);

      // reset while at node 2 and halted
      cla_en = 1'b0; ev = '0; cfg = '0; cyc();
      put(0, 0, mk(1'b1, 13, 20, 2, 1'b0));
      put(2, 0, mk(1'b1, 14, 1, 2, 1'b0));
      cla_en = 1'b1; cyc();
      ev[13] = 1'b1; cyc();
      chk("t6_act", act, 64'h100000);
      ev = '0; ev[14] = 1'b1; cyc();
      chk("t6_halted", {63'd0, halted}, 64'd1);
      chk("t6_self_chg", {63'd0, chg}, 64'd0);
      reset = 1'b1; cyc();
      chk("t6_rst_act", act, 64'd0);
      chk("t6_rst_node", {62'd0, node}, 64'd0);
      chk("t6_rst_halted", {63'd0, halted}, 64'd0);
      reset = 1'b0; cyc();
      chk("t6_idle_act", act, 64'd0);

      // randomised traffic, checked by the model
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 40) == 0) begin
            cla_en = 1'b0;
            for (int w = 0; w < 8; w++) cfg[w*32 +: 32] = $urandom;
         end else begin
            cla_en = 1'b1;
         end
         reset = ($urandom_range(0, 150) == 0);
         ev = {$urandom, $urandom};
         cyc();
      end
      reset = 1'b0;
      cyc();
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
